// File: rtl/rv_sram_fifo_ctrl.sv
// rv_sram_fifo_ctrl: valid/ready FIFO controller around a two-port RVSram.
// It drives the SRAM write port from the producer and the read port for the consumer.
// A 2-entry output stage (SRAM read register plus a skid register) hides the
// 1-cycle registered read latency, so the FIFO can move 1 word/cycle in and out.
// Total capacity is DEPTH words in the SRAM plus 2 in the output stage.
module rv_sram_fifo_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 32
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          sram_wr_en,
  output logic [AW-1:0] sram_wr_addr,
  output logic [DW-1:0] sram_wr_data,
  output logic          sram_rd_en,
  output logic [AW-1:0] sram_rd_addr,
  input  logic [DW-1:0] sram_rd_data
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  // SRAM-side pointers and occupancy (words written but not yet read out)
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   scnt, scnt_n;
  logic [AW:0]   count_q, count_n;

  // Output stage: rd_pend marks a live word on sram_rd_data; the skid word is always older
  logic          rd_pend, rd_pend_n;
  logic          skid_v,  skid_v_n;
  logic [DW-1:0] skid_d,  skid_d_n;

  logic push, pop, rd_issue;

  // Handshakes. in_ready looks at registered state only, so it never
  // depends combinationally on in_valid or out_ready.
  assign in_ready  = (scnt < DEPTH_CNT);
  assign push      = in_valid & in_ready;
  assign out_valid = skid_v | rd_pend;
  assign out_data  = skid_v ? skid_d : sram_rd_data;
  assign pop       = out_valid & out_ready;

  // A read is held off only when both output slots are occupied and nothing
  // leaves this cycle. scnt excludes the word being written right now, so the
  // read address can never collide with this cycle's write address.
  assign rd_issue  = (scnt != '0) & ~(skid_v & rd_pend & ~pop);

  assign sram_wr_en   = push;
  assign sram_wr_addr = wptr;
  assign sram_wr_data = in_data;
  assign sram_rd_en   = rd_issue;
  assign sram_rd_addr = rptr;
  assign count        = count_q;

  // Output-stage next state: decide where the unpopped words of {skid, rd} end up
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    skid_v_n  = skid_v;
    skid_d_n  = skid_d;
    rd_pend_n = rd_pend;
    if (rd_issue) begin
      // The read register is about to be overwritten; its survivor (at most one word) moves to skid.
      rd_pend_n = 1'b1;
      if (skid_v) begin
        if (pop) begin
          skid_v_n = rd_pend;
          skid_d_n = sram_rd_data;
        end
      end else begin
        skid_v_n = rd_pend & ~pop;
        skid_d_n = sram_rd_data;
      end
    end else begin
      // The SRAM holds rd_data while rd_en is low, so the rd word stays in place.
      // A popped skid word leaves rd_pend untouched.
      skid_v_n  = skid_v & ~pop;
      rd_pend_n = rd_pend & ~(pop & ~skid_v);
    end
  end

  // Occupancy counters: push, pop and read issue may all coincide
  always_comb begin
    scnt_n  = scnt + (AW+1)'(push) - (AW+1)'(rd_issue);
    count_n = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Control state register with asynchronous reset
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      scnt    <= '0;
      count_q <= '0;
      rd_pend <= 1'b0;
      skid_v  <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (push)     wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
      if (rd_issue) rptr <= (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
      scnt    <= scnt_n;
      count_q <= count_n;
      rd_pend <= rd_pend_n;
      skid_v  <= skid_v_n;
    end
  end

  // Skid data register
  always_ff @(posedge sclk) begin
    // NOTE: data-only storage is left unreset; skid_v qualifies it, so its reset value is never observed.
    skid_d <= skid_d_n;
  end

endmodule
